inst_word_loader: RTL
=====================

# inst_word_loader

Programming-side word assembler that sits directly upstream of the instruction memory. It takes the byte stream and start address delivered by the I2C programming port, packs every four bytes little-endian into a 32-bit instruction word, and writes it to memory at a word address that auto-increments by 4, matching the program counter step. It is active only while the programming chip-select is high; when chip-select is low the core runs from memory untouched.

## Interface
Parameters:
- ADDR_W, default 8: byte-address width; matches the PC width.
- CNT_W, default 6: width of the words-written counter.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_cs  in  1  programming enable; 1 = loader active, 0 = idle.
- i_addr_valid  in  1  one-cycle strobe; load start address from i_addr.
- i_addr  in  ADDR_W  start byte address.
- i_byte_valid  in  1  one-cycle strobe; i_byte carries the next instruction byte.
- i_byte  in  8  instruction byte.
- o_byte_ready  out  1  loader can accept a byte this cycle.
- o_wr_en  out  1  memory write request; held until acknowledged.
- o_wr_addr  out  ADDR_W  word-aligned write address; o_wr_addr[1:0] is always 0.
- o_wr_data  out  32  assembled word; the first byte received is in [7:0].
- i_wr_ack  in  1  memory accepted the write in this cycle.
- o_busy  out  1  partial word held or write pending.
- o_word_count  out  CNT_W  words written since the last address load; saturates at all-ones.
- o_err  out  1  sticky error flag.

## Operation
- States: IDLE, COLLECT, WRITE.
- IDLE: entered on reset or when i_cs = 0. The loader ignores all strobes. The transition to COLLECT happens on the first cycle with i_cs = 1; on that edge o_err clears.
- COLLECT: the byte index idx runs 0..3. When i_byte_valid && o_byte_ready, byte idx goes into word[8*idx+7 : 8*idx] and idx increments. Accepting the byte at idx = 3 moves the state to WRITE.
- WRITE: o_wr_en = 1 and o_wr_addr / o_wr_data are stable. When i_wr_ack = 1:
  - the address advances by 4, modulo 2^ADDR_W (0xFC wraps to 0x00);
  - o_word_count increments, saturating;
  - idx resets to 0 and the state returns to COLLECT.
- o_byte_ready = i_cs && state == COLLECT.
- i_addr_valid in COLLECT or WRITE:
  - the address register loads {i_addr[ADDR_W-1:2], 2'b00};
  - any partial word or pending write is discarded, idx = 0, o_word_count = 0, and the state goes to COLLECT;
  - if i_addr[1:0] != 0, o_err is set.
- i_byte_valid during WRITE: the byte is dropped and o_err is set (overrun).
- i_addr_valid and i_byte_valid in the same cycle: the address wins, the byte is dropped, and o_err is set.
- i_cs falling in any state: the partial word or pending write is aborted, o_wr_en drops the next cycle, and the state goes to IDLE. The address register and o_word_count keep their values.
- o_busy = (state == COLLECT && idx != 0) || state == WRITE.

## Timing
- Reset values: o_byte_ready 0, o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_busy 0, o_word_count 0, o_err 0, idx 0, state IDLE.
- All outputs are registered or decoded from state only. No combinational path runs from i_byte_valid or i_wr_ack to any output.
- Latency: if the 4th byte is accepted at edge N, o_wr_en = 1 from cycle N+1.
- If i_wr_ack arrives in the first o_wr_en cycle, o_byte_ready is 1 again the following cycle. Peak throughput is 1 word per 5 cycles.
- An address load takes effect at the edge after the strobe; a byte may be accepted in the next cycle.
- o_err stays set until reset or a rising edge of i_cs.

## Structure
- Shared package inst_loader_pkg holds:
  - the state enum (IDLE, COLLECT, WRITE);
  - WORD_BYTES = 4;
  - ADDR_STEP = 4;
  - the byte-lane index type.
- The PC increment uses the same ADDR_STEP constant.
- One natural sub-module: inst_word_packer, which holds the idx counter, the byte-lane write into the 32-bit register, and the "word complete" pulse. The FSM, address counter, word counter and error logic stay in the top module.

## Test plan
- Reset, i_cs = 1, address 0x10, bytes 0x13,0x05,0x10,0x00, ack in the first cycle → one write of 0x00100513 at 0x10; o_word_count = 1; next address 0x14.
- Start address 0xFC, 8 bytes, ack delayed 3 cycles → writes go to 0xFC then 0x00. o_wr_en is held steady during the delay and o_byte_ready = 0 throughout it.
- Byte strobe during WRITE → byte dropped, o_err = 1, written data unchanged. o_err then clears on an i_cs 0→1 cycle.
- Start address 0x07 → o_wr_addr = 0x04 and o_err = 1. Simultaneous address and byte strobes → address loads, byte dropped, o_err = 1.
- 2 bytes sent, then i_cs dropped and raised → no write issued. The next 4 bytes form a fresh word at the same address.
- i_rst asserted in the cycle of the 4th byte → all outputs are 0 the next cycle and no write occurs.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and constants for the instruction word loader
package inst_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_STEP  = 4;

  typedef logic [1:0] byte_lane_t;

endpackage

// File: rtl/inst_word_packer.sv
// rtl/inst_word_packer.sv - little-endian byte-to-word packer with lane counter
module inst_word_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output byte_lane_t  lane,
  output logic [31:0] word,
  output logic        word_done
);

  localparam byte_lane_t LAST_LANE = byte_lane_t'(WORD_BYTES - 1);

  // The accepted byte that lands in the top lane completes the word.
  assign word_done = load && (lane == LAST_LANE);

  // Lane counter and byte-lane write; the word register keeps its last contents
  // when cleared so a pending write never sees its data change underneath it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (load) begin
      word[8*lane +: 8] <= byte_in;
      lane              <= lane + 1'b1;
    end
  end

endmodule

// File: rtl/inst_word_loader.sv
// rtl/inst_word_loader.sv - packs programming bytes into instruction words and writes them to memory
module inst_word_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_addr_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_word_count,
  output logic              o_err
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;

  logic              load_addr, advance, clear_lane, set_err, clr_err;
  logic              accept, word_done;
  byte_lane_t        lane;
  logic [31:0]       word;

  // An address strobe takes priority over a byte in the same cycle.
  assign accept = o_byte_ready && i_byte_valid && !i_addr_valid;

  inst_word_packer u_packer (
    .clk       (i_clk),
    .rst       (i_rst),
    .clear     (clear_lane),
    .load      (accept),
    .byte_in   (i_byte),
    .lane      (lane),
    .word      (word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_next = state;
    load_addr  = 1'b0;
    advance    = 1'b0;
    clear_lane = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state)
      IDLE: begin
        if (i_cs) begin
          state_next = COLLECT;
          clr_err    = 1'b1;
        end
      end
      COLLECT, WRITE: begin
        if (!i_cs) begin
          state_next = IDLE;
          clear_lane = 1'b1;
        end else if (i_addr_valid) begin
          state_next = COLLECT;
          load_addr  = 1'b1;
          clear_lane = 1'b1;
          set_err    = (i_addr[1:0] != 2'b00) || i_byte_valid;
        end else if (state == COLLECT) begin
          if (word_done) state_next = WRITE;
        end else begin
          set_err = i_byte_valid;
          if (i_wr_ack) begin
            state_next = COLLECT;
            advance    = 1'b1;
            clear_lane = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write address, saturating word counter and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load_addr) begin
        addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
        count_q <= '0;
      end else if (advance) begin
        addr_q <= addr_q + ADDR_W'(ADDR_STEP);
        if (count_q != '1) count_q <= count_q + 1'b1;
      end
      if (clr_err)      err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
    end
  end

  assign o_byte_ready = i_cs && (state == COLLECT);
  assign o_wr_en      = (state == WRITE);
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = word;
  assign o_busy       = ((state == COLLECT) && (lane != '0)) || (state == WRITE);
  assign o_word_count = count_q;
  assign o_err        = err_q;

endmodule
